// File: rtl/canvas_writer_if.sv
// Stream bus from the canvas writer to the downstream encoder.
interface canvas_writer_if;
  logic signed [9:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              s_last;

  modport master (output s_data, output s_valid, output s_last, input s_ready);
  modport slave  (input s_data, input s_valid, input s_last, output s_ready);
endinterface

// File: rtl/canvas_writer.sv
// Drawing canvas: pen painting, bulk clear, read-only display port and
// a valid/ready stream of all cells to an encoder.
module canvas_writer #(
  parameter int unsigned       GRID    = 14,
  parameter int unsigned       CELL_PX = 20,
  parameter int unsigned       ORG_X   = 180,
  parameter int unsigned       ORG_Y   = 100,
  parameter logic signed [9:0] PEN_VAL = 10'sd15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [9:0]        cur_x,
  input  logic [9:0]        cur_y,
  input  logic              pen_dn,
  input  logic              erase,
  input  logic              clr,
  input  logic              start,
  input  logic [7:0]        rd_addr,
  output logic signed [9:0] rd_data,
  canvas_writer_if.master   s_if,
  output logic              busy,
  output logic              done
);

  localparam int unsigned DW    = 10;
  localparam int unsigned AW    = 8;
  localparam int unsigned CELLS = GRID * GRID;
  localparam int unsigned SPAN  = GRID * CELL_PX;
  localparam logic [AW-1:0] LAST_IDX = AW'(CELLS - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CLEAR  = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic                 done_q, done_d;
  logic signed [DW-1:0] rd_data_q, rd_data_d;
  logic signed [DW-1:0] mem_q [CELLS];
  logic signed [DW-1:0] mem_d [CELLS];

  logic                 in_canvas;
  logic [DW-1:0]        dx, dy, col, row;
  logic [AW-1:0]        pen_idx;
  logic                 wr_en;
  logic [AW-1:0]        wr_addr;
  logic signed [DW-1:0] wr_data;

  // Cursor hit test and cell index under the cursor (strict bounds).
  always_comb begin
    in_canvas = (cur_x > DW'(ORG_X)) && (cur_x < DW'(ORG_X + SPAN)) &&
                (cur_y > DW'(ORG_Y)) && (cur_y < DW'(ORG_Y + SPAN));
    dx      = cur_x - DW'(ORG_X);
    dy      = cur_y - DW'(ORG_Y);
    col     = dx / DW'(CELL_PX);
    row     = dy / DW'(CELL_PX);
    pen_idx = AW'(col + DW'(GRID) * row);
  end

  // Next state, cell index, write port and done pulse.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    case (state_q)
      S_IDLE: begin
        if (pen_dn && in_canvas) begin
          wr_en   = 1'b1;
          wr_addr = pen_idx;
          wr_data = erase ? '0 : PEN_VAL;
        end
        if (clr) begin
          state_d = S_CLEAR;
          idx_d   = '0;
        end else if (start) begin
          state_d = S_STREAM;
          idx_d   = '0;
        end
      end
      S_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = idx_q;
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      S_STREAM: begin
        if (s_if.s_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Cell array update and registered display read (old value on collision).
  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_addr] = wr_data;
    rd_data_d = (rd_addr < AW'(CELLS)) ? mem_q[rd_addr] : '0;
  end

  // State and storage registers; reset zeroes every cell in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      done_q    <= 1'b0;
      rd_data_q <= '0;
      for (int i = 0; i < int'(CELLS); i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      rd_data_q <= rd_data_d;
      mem_q     <= mem_d;
    end
  end

  assign rd_data     = rd_data_q;
  assign done        = done_q;
  assign busy        = (state_q != S_IDLE);
  assign s_if.s_valid = (state_q == S_STREAM);
  assign s_if.s_data  = (state_q == S_STREAM) ? mem_q[idx_q] : '0;
  assign s_if.s_last  = (state_q == S_STREAM) && (idx_q == LAST_IDX);

endmodule

// File: tb/tb_canvas_writer.sv
// Directed bench for canvas_writer: pen vectors, same-cycle read, stream
// with backpressure, clear, clr/start collision and reset abort.
module tb_canvas_writer;
  logic              clk = 1'b0;
  logic              rst;
  logic [9:0]        cur_x, cur_y;
  logic              pen_dn, erase, clr, start;
  logic [7:0]        rd_addr;
  logic signed [9:0] rd_data;
  logic              busy, done;

  canvas_writer_if sif ();

  canvas_writer dut (
    .clk(clk), .rst(rst), .cur_x(cur_x), .cur_y(cur_y), .pen_dn(pen_dn),
    .erase(erase), .clr(clr), .start(start), .rd_addr(rd_addr),
    .rd_data(rd_data), .s_if(sif), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]        x;
    logic [9:0]        y;
    logic              pen;
    logic              ers;
    logic [7:0]        addr;
    logic signed [9:0] exp;
  } vec_t;

  vec_t vecs[10];
  int checks = 0;
  int errors = 0;
  logic signed [9:0] model [196];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic paint(input logic [9:0] x, input logic [9:0] y, input logic e);
    cur_x = x; cur_y = y; erase = e; pen_dn = 1'b1;
    @(negedge clk);
    pen_dn = 1'b0; erase = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < 196; a++) begin
      rd_addr = 8'(a);
      @(negedge clk);
      chk(tag, int'(rd_data), 0);
    end
  endtask

  initial begin
    int cnt, dones, busy_cnt, post;
    logic seen;

    rst = 1'b1; cur_x = '0; cur_y = '0; pen_dn = 1'b0; erase = 1'b0;
    clr = 1'b0; start = 1'b0; rd_addr = '0; sif.s_ready = 1'b0;

    // x, y, pen, erase, read address, expected cell value
    vecs[0] = '{10'd181, 10'd101, 1'b1, 1'b0, 8'd0,   10'sd15};
    vecs[1] = '{10'd459, 10'd379, 1'b1, 1'b0, 8'd195, 10'sd15};
    vecs[2] = '{10'd180, 10'd150, 1'b1, 1'b0, 8'd28,  10'sd0};
    vecs[3] = '{10'd460, 10'd150, 1'b1, 1'b0, 8'd42,  10'sd0};
    vecs[4] = '{10'd200, 10'd100, 1'b1, 1'b0, 8'd1,   10'sd0};
    vecs[5] = '{10'd459, 10'd379, 1'b1, 1'b1, 8'd195, 10'sd0};
    vecs[6] = '{10'd200, 10'd120, 1'b1, 1'b0, 8'd15,  10'sd15};
    vecs[7] = '{10'd300, 10'd250, 1'b1, 1'b0, 8'd104, 10'sd15};
    vecs[8] = '{10'd320, 10'd250, 1'b0, 1'b0, 8'd105, 10'sd0};
    vecs[9] = '{10'd181, 10'd101, 1'b0, 1'b0, 8'd200, 10'sd0};

    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(sif.s_valid), 0);
    chk("rst_last", int'(sif.s_last), 0);
    chk("rst_sdata", int'(sif.s_data), 0);
    chk("rst_rdata", int'(rd_data), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      cur_x = vecs[i].x; cur_y = vecs[i].y;
      pen_dn = vecs[i].pen; erase = vecs[i].ers;
      @(negedge clk);
      pen_dn = 1'b0; erase = 1'b0;
      rd_addr = vecs[i].addr;
      @(negedge clk);
      chk($sformatf("vec%0d", i), int'(rd_data), int'(vecs[i].exp));
    end

    // Read and erase the same cell on one edge: old value first.
    rd_addr = 8'd104;
    cur_x = 10'd300; cur_y = 10'd250; erase = 1'b1; pen_dn = 1'b1;
    @(negedge clk);
    pen_dn = 1'b0; erase = 1'b0;
    chk("rd_old", int'(rd_data), 15);
    @(negedge clk);
    chk("rd_new", int'(rd_data), 0);

    // Stream with random backpressure.
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 196; i++) model[i] = 10'sd0;
    model[0] = 10'sd15; model[14] = 10'sd15; model[195] = 10'sd15;
    paint(10'd181, 10'd101, 1'b0);
    paint(10'd181, 10'd121, 1'b0);
    paint(10'd459, 10'd379, 1'b0);
    start = 1'b1; @(negedge clk); start = 1'b0;
    chk("stream_busy", int'(busy), 1);
    cur_x = 10'd341; cur_y = 10'd161; pen_dn = 1'b1;
    cnt = 0; dones = 0; post = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (done) dones++;
      if (cnt == 196) begin
        pen_dn = 1'b0;
        post++;
        if (post > 4) break;
      end
      clr   = (cyc == 40);
      start = (cyc == 80);
      sif.s_ready = 1'($urandom_range(0, 1));
      if (cnt < 196) begin
        if (!sif.s_valid) chk("stream_valid", int'(sif.s_valid), 1);
        else begin
          if (sif.s_data != model[cnt])
            chk($sformatf("word%0d", cnt), int'(sif.s_data), int'(model[cnt]));
          if (sif.s_last != (cnt == 195))
            chk($sformatf("last%0d", cnt), int'(sif.s_last), int'(cnt == 195));
          if (sif.s_ready) cnt++;
        end
      end else if (sif.s_valid) begin
        chk("extra_word", int'(sif.s_valid), 0);
      end
      @(negedge clk);
    end
    clr = 1'b0; start = 1'b0; pen_dn = 1'b0; sif.s_ready = 1'b0;
    chk("stream_words", cnt, 196);
    chk("stream_dones", dones, 1);
    chk("stream_idle", int'(busy), 0);
    rd_addr = 8'd50; @(negedge clk);
    chk("pen_in_stream", int'(rd_data), 0);
    rd_addr = 8'd195; @(negedge clk);
    chk("clr_in_stream", int'(rd_data), 15);

    // Clear with pen held on cell 0.
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    cur_x = 10'd181; cur_y = 10'd101; pen_dn = 1'b1;
    busy_cnt = 0; dones = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (done) dones++;
      if (!busy) break;
      busy_cnt++;
      @(negedge clk);
    end
    pen_dn = 1'b0;
    chk("clear_busy_cycles", busy_cnt, 196);
    chk("clear_dones", dones, 1);
    check_all_zero("clear_cell");

    // clr and start together: clear wins, no words.
    paint(10'd181, 10'd101, 1'b0);
    sif.s_ready = 1'b1;
    clr = 1'b1; start = 1'b1; @(negedge clk); clr = 1'b0; start = 1'b0;
    chk("coll_busy", int'(busy), 1);
    seen = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (sif.s_valid) seen = 1'b1;
      if (!busy) break;
      @(negedge clk);
    end
    chk("coll_no_words", int'(seen), 0);
    chk("coll_idle", int'(busy), 0);
    rd_addr = 8'd0; @(negedge clk);
    chk("coll_cell0", int'(rd_data), 0);

    // Reset at word 50 of a stream.
    paint(10'd241, 10'd101, 1'b0);
    start = 1'b1; @(negedge clk); start = 1'b0;
    cnt = 0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (sif.s_valid) begin
        if (cnt == 50) begin
          rst = 1'b1;
          break;
        end
        cnt++;
      end
      @(negedge clk);
    end
    chk("abort_reached", cnt, 50);
    @(negedge clk);
    rst = 1'b0;
    chk("abort_valid", int'(sif.s_valid), 0);
    chk("abort_busy", int'(busy), 0);
    dones = 0; seen = 1'b0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (done) dones++;
      if (sif.s_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_done", dones, 0);
    chk("abort_no_words", int'(seen), 0);
    check_all_zero("abort_cell");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/canvas_writer.md
CANVAS_WRITER -- requirements
Module: canvas_writer

Interface
REQ-001 SHALL have parameter GRID, default 14, meaning cells per canvas row and column (GRID*GRID = 196 cells).
REQ-002 SHALL have parameter CELL_PX, default 20, meaning screen pixels per cell edge.
REQ-003 SHALL have parameter ORG_X, default 180, meaning the canvas left edge; ORG_Y, default 100, meaning the canvas top edge.
REQ-004 SHALL have parameter PEN_VAL, default 10'sd15, meaning the signed value written by the pen.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 cur_x  input  10  cursor screen x.
REQ-008 cur_y  input  10  cursor screen y.
REQ-009 pen_dn  input  1  level; paint the cell under the cursor.
REQ-010 erase  input  1  level; when set with pen_dn, write 0 instead of PEN_VAL.
REQ-011 clr  input  1  one-cycle pulse; zero the entire canvas.
REQ-012 start  input  1  one-cycle pulse; stream the canvas to the encoder.
REQ-013 rd_addr  input  8  display read address (cell index 0..195).
REQ-014 rd_data  output  10  signed cell value for rd_addr.
REQ-015 s_data  output  10  signed stream word; s_valid output 1; s_ready input 1; s_last output 1.
REQ-016 busy  output  1  high in CLEAR or STREAM; done output 1, one-cycle pulse at the end of a clear or a stream.

Function
REQ-017 SHALL hold 196 x 10-bit signed cells, with cell index = col + 14*row, row-major.
REQ-018 Cursor in the canvas SHALL mean ORG_X < cur_x < ORG_X+280 and ORG_Y < cur_y < ORG_Y+280, strict on both bounds.
REQ-019 The cursor cell SHALL be col=(cur_x-ORG_X)/CELL_PX and row=(cur_y-ORG_Y)/CELL_PX, using unsigned 10-bit arithmetic.
REQ-020 FSM states SHALL be IDLE, CLEAR, STREAM; reset state IDLE.
REQ-021 In IDLE, with pen_dn=1 and the cursor in the canvas, the cursor cell SHALL be written on that edge (PEN_VAL, or 0 if erase=1); outside the canvas there SHALL be no write.
REQ-022 IDLE -> CLEAR on clr: write 0 to one cell per cycle at index 0..195; after writing 195, pulse done and return to IDLE (196 cycles).
REQ-023 IDLE -> STREAM on start: the stream index starts at 0.
REQ-024 In STREAM, s_valid=1 and s_data=cell[index]; on s_valid&&s_ready the index increments.
REQ-025 In STREAM, s_last=1 only while index=195; a handshake with s_last SHALL pulse done and return to IDLE.
REQ-026 While s_valid=1 and s_ready=0, s_data, s_last and the index SHALL hold.
REQ-027 clr and start asserted in the same IDLE cycle: clr wins and start is dropped.
REQ-028 clr or start asserted outside IDLE SHALL be ignored, not queued.
REQ-029 pen_dn outside IDLE SHALL be ignored, so that a streamed frame is stable.
REQ-030 rd_data SHALL be registered with 1-cycle latency; rd_addr>=196 SHALL return 0.
REQ-031 A display read of a cell written in the same cycle SHALL return the old value.
REQ-032 The read port SHALL be independent of FSM state.
REQ-033 busy SHALL be combinational from state; s_valid=0 and s_last=0 outside STREAM.

Reset
REQ-034 rst SHALL force IDLE and set busy=0, done=0, s_valid=0, s_last=0, s_data=0, rd_data=0.
REQ-035 rst SHALL zero all 196 cells within the reset cycle; this takes precedence over any in-progress CLEAR or STREAM.
REQ-036 A stream aborted by rst SHALL emit no further words and SHALL NOT pulse done.

Verification
REQ-037 Pen write: reset; cur_x=181, cur_y=101, pen_dn=1 for 1 cycle; then rd_addr=0 -> rd_data=15 the next cycle.
REQ-038 Edges and erase:
- cur_x=459, cur_y=379 writes cell 195.
- cur_x=180 or cur_x=460 writes nothing.
- pen_dn with erase=1 at cell 195 -> cell 195 reads 0.
REQ-039 Stream with backpressure: paint cells 0, 14 and 195; pulse start; toggle s_ready at random.
- Exactly 196 words are accepted, in order, with values 15 at indices 0, 14 and 195 and 0 elsewhere.
- s_last is high only on word 195; done pulses once; words hold while s_ready=0.
REQ-040 Clear: paint cells, then pulse clr -> busy=1 for 196 cycles, done pulses once, every rd_addr reads 0; pen_dn during the clear has no effect.
REQ-041 Collisions and abort:
- clr and start in the same cycle -> CLEAR; no stream words are emitted.
- rst at word 50 of a stream -> s_valid drops next cycle, no done pulse, all cells read 0.
